// File: rtl/alu_booth_mul24.sv
`default_nettype none
// ============================================================================
//  Module   : alu_booth_mul24 (with helper RippleCarryAdder24)
//  Purpose  : Sequential radix-2 Booth multiplier for the 24-bit signed ALU
//             datapath. One 25-bit add/subtract per clock through a single
//             ripple-carry adder, followed by an arithmetic right shift of
//             {ACC,Q,Qm1}. 24 iterations yield a 48-bit signed product.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-high reset
//             start    - request, honoured only in IDLE or DONE
//             a, b     - signed multiplicand / multiplier (24 bit)
//             busy     - high while iterating (RUN)
//             done     - one-cycle pulse when product is valid (DONE)
//             product  - 48-bit signed result, held until next accepted start
//             ovf      - product does not fit 24-bit signed
//                        (present only when ALU_MUL_OVF_EN is defined)
//  Config   : ALU_MUL_OVF_EN - adds the registered ovf output
//  Revision : 1.0 - initial release
// ============================================================================

// 25-bit ripple-carry adder sized for the sign-extended accumulator.
// Carry out is not exposed: the Booth accumulator never needs it.
module RippleCarryAdder24 (
  input  logic [24:0] a,
  input  logic [24:0] b,
  input  logic        cin,
  output logic [24:0] sum
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < 25; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

module alu_booth_mul24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        busy,
  output logic        done,
  output logic [47:0] product
`ifdef ALU_MUL_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [24:0] m;
  logic [24:0] acc;
  logic [23:0] q;
  logic        qm1;
  logic [4:0]  cnt;

  logic [24:0] add_b;
  logic        add_cin;
  logic [24:0] sum;
  logic        accept;
  logic        last_iter;
  logic [47:0] product_next;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == RUN) && (cnt == 5'd23);

  // Final shifted {ACC[23:0],Q}: after the last shift ACC[23:0] = S[24:1]
  // and Q = {S[0],Q[23:1]}, so the product is simply {S, Q[23:1]}.
  assign product_next = {sum, q[23:1]};

  // Booth recoding of {Q[0],Qm1}: 01 adds M, 10 subtracts M (two's
  // complement via ~M with carry-in), 00/11 pass ACC through unchanged.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      case ({q[0], qm1})
        2'b01:   add_b = m;
        2'b10: begin
          add_b   = ~m;
          add_cin = 1'b1;
        end
        default: add_b = '0;
      endcase
    end
  end

  RippleCarryAdder24 u_adder (
    .a   (acc),
    .b   (add_b),
    .cin (add_cin),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == 5'd23) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      m   <= {a[23], a};
      acc <= '0;
      q   <= b;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= {sum[24], sum[24:1]};
      q   <= {sum[0], q[23:1]};
      qm1 <= q[0];
      cnt <= cnt + 5'd1;
      if (last_iter) begin
        product <= product_next;
      end
    end
  end

`ifdef ALU_MUL_OVF_EN
  // The product fits 24-bit signed only when bits 47..23 are all copies of
  // the sign bit.
  logic [24:0] upper_bits;
  assign upper_bits = product_next[47:23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_iter) begin
      ovf <= ~((&upper_bits) | (~|upper_bits));
    end
  end
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_booth_mul24.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_booth_mul24
//  Purpose  : Scoreboard bench for alu_booth_mul24. Stimulus pushes the
//             expected product (from plain signed arithmetic) into a queue;
//             an independent monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_booth_mul24;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        done;
  logic [47:0] product;
`ifdef ALU_MUL_OVF_EN
  logic        ovf;
`endif

  typedef struct {
    logic [47:0] p;
    logic        ov;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic prev_done = 1'b0;

  alu_booth_mul24 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef ALU_MUL_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact signed product with wide integer arithmetic.
  task automatic ref_mul(input logic [23:0] x, input logic [23:0] y,
                         output logic [47:0] p, output logic ov);
    longint r;
    r  = longint'($signed(x)) * longint'($signed(y));
    p  = r[47:0];
    ov = (r < -64'sd8388608) || (r > 64'sd8388607);
  endtask

  function automatic logic [23:0] rnd24();
    logic [23:0] v;
    case ($urandom_range(0, 6))
      0:       v = 24'h800000;
      1:       v = 24'h7FFFFF;
      2:       v = 24'h000000;
      3:       v = 24'hFFFFFF;
      default: v = 24'($urandom);
    endcase
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      check("done_single_cycle", {63'd0, prev_done}, 64'd0);
      check("busy_low_in_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("product", {16'd0, product}, {16'd0, e.p});
        check("latency", 64'(cyc - e.issue), 64'd25);
`ifdef ALU_MUL_OVF_EN
        check("ovf", {63'd0, ovf}, {63'd0, e.ov});
`endif
      end
    end
    prev_done <= done;
  end

  // Drive operands with start=1 at the current (negedge) time.
  task automatic issue(input logic [23:0] x, input logic [23:0] y,
                       input logic [47:0] p, input logic ov, input bit push);
    exp_t e;
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) begin
      e.p     = p;
      e.ov    = ov;
      e.issue = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_single(input logic [23:0] x, input logic [23:0] y,
                            input logic [47:0] p, input logic ov);
    @(negedge clk);
    issue(x, y, p, ov, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic run_random();
    logic [23:0] x, y;
    logic [47:0] p;
    logic        ov;
    x = rnd24();
    y = rnd24();
    ref_mul(x, y, p, ov);
    run_single(x, y, p, ov);
  endtask

  initial begin
    logic [23:0] x, y;
    logic [47:0] p;
    logic        ov;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", {16'd0, product}, 64'd0);
`ifdef ALU_MUL_OVF_EN
    check("reset_ovf", {63'd0, ovf}, 64'd0);
`endif
    rst = 1'b0;

    // Directed products with hand-computed results.
    run_single(24'd3,      24'd5,      48'h00000000000F, 1'b0);
    run_single(24'hFFFFF9, 24'd6,      48'hFFFFFFFFFFD6, 1'b0);
    run_single(24'd6,      24'hFFFFF9, 48'hFFFFFFFFFFD6, 1'b0);
    run_single(24'h800000, 24'h800000, 48'h400000000000, 1'b1);
    run_single(24'h7FFFFF, 24'h7FFFFF, 48'h3FFFFF000001, 1'b1);

    // start pulsed mid-run with new operands must be ignored.
    @(negedge clk);
    issue(24'd3, 24'd5, 48'h00000000000F, 1'b0, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    a     = 24'd9;
    b     = 24'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of a run (not expected to complete).
    @(negedge clk);
    issue(24'd3, 24'd5, 48'd0, 1'b0, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset_busy", {63'd0, busy}, 64'd0);
    check("midrun_reset_done", {63'd0, done}, 64'd0);
    check("midrun_reset_product", {16'd0, product}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_single(24'd2, 24'hFFFFFE, 48'hFFFFFFFFFFFC, 1'b0);

    // Randomised single operations.
    for (int i = 0; i < 12; i++) run_random();

    // Back-to-back: start held high, new pair presented in each DONE cycle.
    @(negedge clk);
    x = rnd24();
    y = rnd24();
    ref_mul(x, y, p, ov);
    issue(x, y, p, ov, 1);
    for (int k = 1; k < 5; k++) begin
      wait_done();
      x = rnd24();
      y = rnd24();
      ref_mul(x, y, p, ov);
      issue(x, y, p, ov, 1);
    end
    wait_done();
    start = 1'b0;

    // Idle period: any stray done pulse is flagged by the monitor.
    repeat (30) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
